// File: rtl/swc_rtu_rsp_buffer.sv
// -----------------------------------------------------------------------------
// swc_rtu_rsp_buffer
//
// Per-port FIFO buffering of routing table unit (RTU) responses on their way
// to the switch core input blocks. Each port owns an independent FIFO holding
// {destination mask, drop flag, priority}. The RTU can therefore hand over a
// decision before the input block is ready to consume it. Entries pass through
// unmodified and in strict FIFO order per port. Entries with drop=1 are
// forwarded like any other entry.
//
// Parameters
//   g_num_ports  : number of switch ports N (1..32)
//   g_prio_width : priority field width P
//   g_depth      : entries per port FIFO (power of two, >= 2)
//   g_cnt_width  : width of the optional stall statistics counters
//
// Ports
//   clk_i                 in   1     system clock, rising edge
//   rst_n_i               in   1     asynchronous active-low reset
//   rtu_rsp_valid_i       in   N     per-port response valid from RTU
//   rtu_rsp_ack_o         out  N     per-port accept (valid & not full)
//   rtu_dst_port_mask_i   in   N*N   port i mask at [i*N +: N]
//   rtu_drop_i            in   N     per-port drop flag
//   rtu_prio_i            in   N*P   port i priority at [i*P +: P]
//   core_rsp_valid_o      out  N     per-port FIFO non-empty
//   core_rsp_ack_i        in   N     core pops head when valid_o & ack_i
//   core_dst_port_mask_o  out  N*N   head mask, same packing as input
//   core_drop_o           out  N     head drop flag
//   core_prio_o           out  N*P   head priority, same packing as input
//   stat_port_i           in   clog2(N) (min 1)  statistics port select
//   stat_clr_i            in   1     clear all statistics counters
//   stat_cnt_o            out  g_cnt_width  registered stall count of the
//                                    selected port (0 if select >= N)
//
// Compile-time option
//   SWC_RTU_RSP_STATS_EN : when defined, a saturating stall counter per port
//                          counts cycles in which the RTU offers a response to
//                          a full FIFO. When undefined, no counters exist,
//                          stat_cnt_o is tied to 0 and the stat inputs are
//                          ignored. FIFO behaviour is the same in both builds.
// -----------------------------------------------------------------------------
module swc_rtu_rsp_buffer #(
  parameter int g_num_ports  = 7,
  parameter int g_prio_width = 3,
  parameter int g_depth      = 4,
  parameter int g_cnt_width  = 16
) (
  input  logic                                             clk_i,
  input  logic                                             rst_n_i,

  input  logic [g_num_ports-1:0]                           rtu_rsp_valid_i,
  output logic [g_num_ports-1:0]                           rtu_rsp_ack_o,
  input  logic [g_num_ports*g_num_ports-1:0]               rtu_dst_port_mask_i,
  input  logic [g_num_ports-1:0]                           rtu_drop_i,
  input  logic [g_num_ports*g_prio_width-1:0]              rtu_prio_i,

  output logic [g_num_ports-1:0]                           core_rsp_valid_o,
  input  logic [g_num_ports-1:0]                           core_rsp_ack_i,
  output logic [g_num_ports*g_num_ports-1:0]               core_dst_port_mask_o,
  output logic [g_num_ports-1:0]                           core_drop_o,
  output logic [g_num_ports*g_prio_width-1:0]              core_prio_o,

  input  logic [((g_num_ports > 1) ? $clog2(g_num_ports) : 1)-1:0] stat_port_i,
  input  logic                                             stat_clr_i,
  output logic [g_cnt_width-1:0]                           stat_cnt_o
);

  localparam int c_sel_width   = (g_num_ports > 1) ? $clog2(g_num_ports) : 1;
  localparam int c_ptr_width   = $clog2(g_depth);
  localparam int c_occ_width   = c_ptr_width + 1;
  localparam int c_entry_width = g_num_ports + 1 + g_prio_width;

  // Per-port full flag, shared between the channels and the statistics block.
  logic [g_num_ports-1:0] w_full;

  // ---------------------------------------------------------------------------
  // FIFO channels, one per port, completely independent of each other.
  // Entry layout: {mask[N-1:0], drop, prio[P-1:0]}.
  // ---------------------------------------------------------------------------
  for (genvar gp = 0; gp < g_num_ports; gp++) begin : g_chan
    logic [c_entry_width-1:0] r_mem [g_depth];
    logic [c_ptr_width-1:0]   r_wptr;
    logic [c_ptr_width-1:0]   r_rptr;
    logic [c_occ_width-1:0]   r_count;

    logic                     w_empty;
    logic                     w_push;
    logic                     w_pop;
    logic [c_entry_width-1:0] w_wr_entry;
    logic [c_entry_width-1:0] w_head;

    // Full and accept depend only on the registered count. A pop in the same
    // cycle does not free a slot for a push, so there is no combinational
    // path from core_rsp_ack_i to rtu_rsp_ack_o.
    assign w_full[gp] = (r_count == c_occ_width'(g_depth));
    assign w_empty    = (r_count == '0);
    assign w_push     = rtu_rsp_valid_i[gp] & ~w_full[gp];
    assign w_pop      = core_rsp_ack_i[gp] & ~w_empty;

    assign w_wr_entry = {rtu_dst_port_mask_i[gp*g_num_ports +: g_num_ports],
                         rtu_drop_i[gp],
                         rtu_prio_i[gp*g_prio_width +: g_prio_width]};

    // Storage is reset as well. This makes the head outputs read 0 after
    // reset. It also ensures that entries queued before a mid-operation
    // reset can never resurface.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        for (int e = 0; e < g_depth; e++) begin
          r_mem[e] <= '0;
        end
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_mem[r_wptr] <= w_wr_entry;
          r_wptr        <= r_wptr + 1'b1;
        end
        if (w_pop) begin
          r_rptr <= r_rptr + 1'b1;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end

    // The head is read straight from storage. A newly written entry becomes
    // visible one cycle after acceptance because there is no write-to-read
    // bypass.
    assign w_head = r_mem[r_rptr];

    assign rtu_rsp_ack_o[gp]    = w_push;
    assign core_rsp_valid_o[gp] = ~w_empty;
    assign core_dst_port_mask_o[gp*g_num_ports +: g_num_ports] =
      w_head[c_entry_width-1 -: g_num_ports];
    assign core_drop_o[gp] = w_head[g_prio_width];
    assign core_prio_o[gp*g_prio_width +: g_prio_width] =
      w_head[g_prio_width-1:0];
  end

  // ---------------------------------------------------------------------------
  // Optional stall statistics
  // ---------------------------------------------------------------------------
`ifdef SWC_RTU_RSP_STATS_EN
  logic [g_cnt_width-1:0] r_stall_cnt [g_num_ports];
  logic [g_cnt_width-1:0] w_sel_cnt;
  logic [g_cnt_width-1:0] r_stat_cnt;

  // A stall is a cycle in which the RTU offers a response but the FIFO is
  // full. Counters saturate at all-ones. Clear takes priority over increment.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < g_num_ports; i++) begin
        r_stall_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < g_num_ports; i++) begin
        if (stat_clr_i) begin
          r_stall_cnt[i] <= '0;
        end else if (rtu_rsp_valid_i[i] && w_full[i] && !(&r_stall_cnt[i])) begin
          r_stall_cnt[i] <= r_stall_cnt[i] + 1'b1;
        end
      end
    end
  end

  // A compare-based mux, so that selects >= N fall through to 0 without
  // indexing past the counter array.
  always_comb begin
    w_sel_cnt = '0;
    for (int i = 0; i < g_num_ports; i++) begin
      if (stat_port_i == c_sel_width'(i)) begin
        w_sel_cnt = r_stall_cnt[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_stat_cnt <= '0;
    end else begin
      r_stat_cnt <= w_sel_cnt;
    end
  end

  assign stat_cnt_o = r_stat_cnt;
`else
  // Statistics are not built. The select and clear inputs have no function.
  logic w_unused_stat;
  assign w_unused_stat = ^{stat_port_i, stat_clr_i};
  assign stat_cnt_o    = '0;
`endif

endmodule
